// File: rtl/output_pulser_pkg.sv
// Shared types, default parameters and width clamp for the output_pulser block.
package output_pulser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_COUNTERWIDTH = 4;
    localparam int DEF_MINWIDTH     = 5;
    localparam int DEF_GAPTIME      = 5;

    function automatic int unsigned max_width(input int unsigned req, input int unsigned min_val);
        return (req > min_val) ? req : min_val;
    endfunction

endpackage

// File: rtl/output_pulser_timer.sv
// pulse_timer: up-counter with clear/load-to-one and a terminal compare, shared
// by the HIGH and GAP phases of output_pulser.
module pulse_timer #(
    parameter int width = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [width-1:0] i_limit,
    output logic             o_term
);

    logic [width-1:0] r_count;

    // Counter register: clear wins over load, load wins over increment.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= width'(1);
        end else if (i_inc) begin
            r_count <= r_count + width'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_term = (r_count == i_limit);

endmodule

// File: rtl/output_pulser.sv
// output_pulser: turns accepted one-cycle requests into a clamped-width high pulse
// followed by a fixed low gap. Optional macro OUTPUT_PULSER_QUEUE_EN adds a
// one-entry pending slot so back-to-back pulses need no idle cycle.
module output_pulser
    import output_pulser_pkg::*;
#(
    parameter int counterwidth = DEF_COUNTERWIDTH,
    parameter int minwidth     = DEF_MINWIDTH,
    parameter int gaptime      = DEF_GAPTIME
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    input  logic [counterwidth-1:0] req_width,
    output logic                    req_ready,
    output logic                    pin_out,
    output logic                    busy,
    output logic                    done
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_pin;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_ready;
    logic                    w_pin_next;
    logic                    w_busy_next;
    logic                    w_done_next;
    logic                    w_ready_next;
    logic [counterwidth-1:0] r_width;
    logic [counterwidth-1:0] w_width_next;
    logic [counterwidth-1:0] w_eff;
    logic [counterwidth-1:0] w_limit;
    logic                    w_accept;
    logic                    w_tmr_clear;
    logic                    w_tmr_load;
    logic                    w_tmr_inc;
    logic                    w_tmr_term;
`ifdef OUTPUT_PULSER_QUEUE_EN
    logic                    r_slot_full;
    logic [counterwidth-1:0] r_slot_width;
    logic                    w_slot_full_next;
    logic [counterwidth-1:0] w_slot_width_next;
`endif

    assign w_accept = req_valid && r_ready;
    assign w_eff    = counterwidth'(max_width(32'(req_width), 32'(minwidth)));
    // Kept outside the FSM block so the timer compare does not loop back through it.
    assign w_limit  = (r_state == GAP) ? counterwidth'(gaptime) : r_width;

    pulse_timer #(
        .width (counterwidth)
    ) u_timer (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_clear   (w_tmr_clear),
        .i_load    (w_tmr_load),
        .i_inc     (w_tmr_inc),
        .i_limit   (w_limit),
        .o_term    (w_tmr_term)
    );

    // Next state, next registered outputs and timer control.
    always_comb begin
        w_state_next = r_state;
        w_pin_next   = 1'b0;
        w_done_next  = 1'b0;
        w_width_next = r_width;
        w_tmr_clear  = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_inc    = 1'b0;
`ifdef OUTPUT_PULSER_QUEUE_EN
        w_slot_full_next  = r_slot_full;
        w_slot_width_next = r_slot_width;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = HIGH;
                    w_pin_next   = 1'b1;
                    w_tmr_load   = 1'b1;
                    w_width_next = w_eff;
                end else begin
                    w_tmr_clear  = 1'b1;
                end
            end
            HIGH: begin
                if (w_tmr_term) begin
                    w_state_next = GAP;
                    w_pin_next   = 1'b0;
                    w_tmr_load   = 1'b1;
                end else begin
                    w_pin_next   = 1'b1;
                    w_tmr_inc    = 1'b1;
                end
`ifdef OUTPUT_PULSER_QUEUE_EN
                if (w_accept) begin
                    w_slot_full_next  = 1'b1;
                    w_slot_width_next = w_eff;
                end else begin
                    w_slot_full_next  = r_slot_full;
                end
`endif
            end
            GAP: begin
                if (w_tmr_term) begin
                    w_done_next = 1'b1;
`ifdef OUTPUT_PULSER_QUEUE_EN
                    // A pending or simultaneously arriving request relaunches with no idle cycle.
                    if (r_slot_full) begin
                        w_state_next     = HIGH;
                        w_pin_next       = 1'b1;
                        w_tmr_load       = 1'b1;
                        w_width_next     = r_slot_width;
                        w_slot_full_next = 1'b0;
                    end else if (w_accept) begin
                        w_state_next = HIGH;
                        w_pin_next   = 1'b1;
                        w_tmr_load   = 1'b1;
                        w_width_next = w_eff;
                    end else begin
                        w_state_next = IDLE;
                        w_tmr_clear  = 1'b1;
                    end
`else
                    w_state_next = IDLE;
                    w_tmr_clear  = 1'b1;
`endif
                end else begin
                    w_tmr_inc = 1'b1;
`ifdef OUTPUT_PULSER_QUEUE_EN
                    if (w_accept) begin
                        w_slot_full_next  = 1'b1;
                        w_slot_width_next = w_eff;
                    end else begin
                        w_slot_full_next  = r_slot_full;
                    end
`endif
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tmr_clear  = 1'b1;
            end
        endcase

        w_busy_next = (w_state_next != IDLE);
`ifdef OUTPUT_PULSER_QUEUE_EN
        w_ready_next = !w_slot_full_next;
`else
        w_ready_next = (w_state_next == IDLE);
`endif
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_pin   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
            r_width <= '0;
        end else begin
            r_state <= w_state_next;
            r_pin   <= w_pin_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_ready <= w_ready_next;
            r_width <= w_width_next;
        end
    end

`ifdef OUTPUT_PULSER_QUEUE_EN
    // Pending-request slot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_slot_full  <= 1'b0;
            r_slot_width <= '0;
        end else begin
            r_slot_full  <= w_slot_full_next;
            r_slot_width <= w_slot_width_next;
        end
    end
`endif

    assign req_ready = r_ready;
    assign pin_out   = r_pin;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_output_pulser.sv
// Directed self-checking bench for output_pulser (default parameters).
module tb_output_pulser;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic [3:0] req_width;
    logic       req_ready;
    logic       pin_out;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    output_pulser dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_width (req_width),
        .req_ready (req_ready),
        .pin_out   (pin_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Expected vectors are {pin_out, busy, done, req_ready}.
    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] o;
        o = {pin_out, busy, done, req_ready};
        n_cmp++;
        assert (o === exp) else begin
            n_err++;
            $error("FAIL %s: observed pin/busy/done/ready=%b expected %b", tag, o, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int n, input logic [3:0] exp);
        for (int i = 0; i < n; i++) begin
            chk(tag, exp);
            @(negedge clk);
        end
    endtask

    // Issue one request from IDLE and check the full high/gap/done sequence.
    task automatic pulse(input logic [3:0] w, input int exp_high, input string tag);
        req_valid = 1'b1;
        req_width = w;
        @(negedge clk);
        req_valid = 1'b0;
        req_width = ~w;
        chk_n({tag, "_high"}, exp_high, 4'b1100);
        chk_n({tag, "_gap"}, 5, 4'b0100);
        chk({tag, "_done"}, 4'b0011);
        @(negedge clk);
        chk({tag, "_idle"}, 4'b0001);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b1;
        req_width = 4'd8;
        @(negedge clk);
        chk_n("reset", 3, 4'b0001);
        req_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        chk("post_reset", 4'b0001);

        pulse(4'd8,  8,  "w8");
        pulse(4'd2,  5,  "w2");
        pulse(4'd0,  5,  "w0");
        pulse(4'd15, 15, "w15");

        req_valid = 1'b1;
        req_width = 4'd10;
        @(negedge clk);
        req_valid = 1'b0;
        chk_n("mid_high", 3, 4'b1100);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst", 4'b0001);
        reset_n = 1'b1;
        @(negedge clk);
        chk_n("after_rst", 2, 4'b0001);
        pulse(4'd6, 6, "w6");

`ifdef OUTPUT_PULSER_QUEUE_EN
        req_valid = 1'b1;
        req_width = 4'd6;
        @(negedge clk);
        req_width = 4'd7;
        chk("q_first", 4'b1101);
        @(negedge clk);
        req_valid = 1'b0;
        chk_n("q_high1", 5, 4'b1100);
        chk_n("q_gap1", 5, 4'b0100);
        chk("q_done1", 4'b1111);
        @(negedge clk);
        chk_n("q_high2", 6, 4'b1101);
        chk_n("q_gap2", 5, 4'b0101);
        chk("q_done2", 4'b0011);
        @(negedge clk);
        chk("q_idle", 4'b0001);
`else
        req_valid = 1'b1;
        req_width = 4'd5;
        @(negedge clk);
        req_width = 4'd7;
        chk_n("held_h1", 5, 4'b1100);
        chk_n("held_gap", 5, 4'b0100);
        chk("held_done", 4'b0011);
        @(negedge clk);
        req_valid = 1'b0;
        chk_n("held_h2", 7, 4'b1100);
        chk_n("held_gap2", 5, 4'b0100);
        chk("held_done2", 4'b0011);
        @(negedge clk);
        chk("held_idle", 4'b0001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/output_pulser.md
Name: output_pulser

Overview:
- Transmit-side counterpart of the input conditioner: turns one-cycle pulse requests into clean pulses on an output pin.
- Every high pulse and every following low gap lasts long enough for a downstream synchroniser/debouncer to register it.
- A single clock domain drives a valid/ready request port, a timed three-state FSM and a registered pin output.

Parameters:
- counterwidth, 4, width of the width field and the internal counter.
- minwidth, 5, minimum high time in cycles. Legal range 1..2^counterwidth-1.
- gaptime, 5, mandatory low time in cycles after each pulse. Legal range 1..2^counterwidth-1.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req_valid  input  1  request present.
- req_width  input  counterwidth  requested high time in cycles.
- req_ready  output  1  request can be accepted this cycle.
- pin_out  output  1  registered pulse output.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse at the end of each gap.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, pin_out=0, busy=0, done=0, req_ready=1, counter=0, any latched width cleared. Requests presented while reset_n=0 are ignored.
- All outputs are registered.
- Acceptance occurs at a rising edge where req_valid && req_ready.
- Effective width = max(req_width, minwidth). req_width=0 is clamped to minwidth. No wrap occurs: the maximum width is 2^counterwidth-1.
- IDLE:
  - req_ready=1, pin_out=0.
  - On acceptance: pin_out=1 from that same edge, counter=1, go to HIGH, req_ready=0, busy=1.
- HIGH:
  - pin_out stays 1 for exactly the effective width in cycles (counted edges).
  - When counter equals the effective width: pin_out=0, counter=1, go to GAP.
- GAP:
  - pin_out=0 for exactly gaptime cycles.
  - When counter equals gaptime: go to IDLE with req_ready=1, busy=0, done=1 for that one cycle.
- Latency: pin_out rises 0 cycles after the accepting edge. A new request can be accepted no earlier than effective width + gaptime cycles after the previous one.
- req_valid during HIGH/GAP is ignored (req_ready=0). The requester must hold req_valid until it is accepted.
- Reset mid-pulse or mid-gap: pin_out=0 at that edge, FSM returns to IDLE, done is not pulsed.
- req_width is sampled only at acceptance. Later changes have no effect.

Optional Feature:
- Macro: OUTPUT_PULSER_QUEUE_EN.
- Defined:
  - Adds a one-entry pending slot. req_ready = slot empty in every state.
  - A request accepted during HIGH/GAP is stored with its clamped width.
  - At the edge where GAP completes: done=1, and if the slot is full, pin_out=1 immediately (zero idle cycles), counter=1, state HIGH, slot cleared.
  - When the slot is empty, the FSM goes to IDLE as normal.
  - In IDLE with the slot empty, a request starts directly with the same timing as the base block.
  - Reset clears the slot.
- Undefined: base behaviour above. No slot logic or storage is synthesised.

Decomposition:
- Package output_pulser_pkg holds:
  - state enum IDLE/HIGH/GAP (2 bits);
  - default constants for counterwidth, minwidth and gaptime;
  - a clamp function max_width(req, min).
- One natural sub-module: pulse_timer, an up-counter with load/clear and a terminal-compare output, instantiated once and shared by HIGH and GAP.

Test Plan (defaults: counterwidth=4, minwidth=5, gaptime=5):
- Reset: reset_n=0 for 3 cycles with req_valid=1, req_width=8 -> pin_out=0, busy=0, done=0 throughout; req_ready=1 on the first cycle after release.
- Width 8 accepted at edge T -> pin_out=1 for edges T..T+7, 0 from T+8; done=1 and req_ready=1 at T+13 only; busy=1 from T to T+12.
- Clamping: width 2 -> high 5 cycles; width 0 -> high 5 cycles; width 15 -> high exactly 15 cycles with no counter wrap.
- Reset mid-pulse: width 10 accepted, reset_n=0 at the 4th high cycle -> pin_out=0 at that edge, state IDLE, no done pulse; a width-6 request afterwards produces a normal 6-cycle pulse.
- Held request: req_valid kept high during GAP with width 7 -> not accepted until req_ready returns; pin_out rises on the accepting edge (base build).
- OUTPUT_PULSER_QUEUE_EN: widths 6 then 7, the second presented during HIGH -> pin_out high 6, low 5, high 7, low 5 with no idle cycle between; done pulses twice; req_ready low only while the slot is full.
